// File: rtl/wb2ahb.sv
// Wishbone classic slave to AHB master bridge: each WB cycle becomes one AHB SINGLE NONSEQ transfer.
// Retries on RETRY/SPLIT up to MAX_RETRY times, then reports wb_err.
module wb2ahb #(
  parameter int           ADDR_WIDTH = 2,
  parameter int           DATA_WIDTH = 8,
  parameter logic [2:0]   HSIZE_VAL  = 3'b000,
  parameter int           MAX_RETRY  = 3
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst,
  input  logic                  wb_cyc,
  input  logic                  wb_stb,
  input  logic                  wb_we,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data_in,
  output logic [DATA_WIDTH-1:0] wb_data_out,
  output logic                  wb_ack,
  output logic                  wb_err,
  output logic                  hclk,
  output logic                  hresetn,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [2:0]            hburst,
  output logic [DATA_WIDTH-1:0] hwdata,
  input  logic [DATA_WIDTH-1:0] hrdata,
  input  logic                  hready,
  input  logic [1:0]            hresp
);

  localparam int             CNT_W         = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT     = CNT_W'(MAX_RETRY);
  localparam logic [1:0]     HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]     HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0]     HRESP_OKAY    = 2'b00;
  localparam logic [1:0]     HRESP_ERROR   = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t                r_state,  w_state_next;
  logic [ADDR_WIDTH-1:0] r_haddr,  w_haddr_next;
  logic [1:0]            r_htrans, w_htrans_next;
  logic                  r_hwrite, w_hwrite_next;
  logic [DATA_WIDTH-1:0] r_hwdata, w_hwdata_next;
  logic [DATA_WIDTH-1:0] r_wdata,  w_wdata_next;
  logic [DATA_WIDTH-1:0] r_dout,   w_dout_next;
  logic                  r_ack,    w_ack_next;
  logic                  r_err,    w_err_next;
  logic [CNT_W-1:0]      r_retry_cnt, w_retry_cnt_next;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_state     <= S_IDLE;
      r_haddr     <= '0;
      r_htrans    <= HTRANS_IDLE;
      r_hwrite    <= 1'b0;
      r_hwdata    <= '0;
      r_wdata     <= '0;
      r_dout      <= '0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_retry_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_haddr     <= w_haddr_next;
      r_htrans    <= w_htrans_next;
      r_hwrite    <= w_hwrite_next;
      r_hwdata    <= w_hwdata_next;
      r_wdata     <= w_wdata_next;
      r_dout      <= w_dout_next;
      r_ack       <= w_ack_next;
      r_err       <= w_err_next;
      r_retry_cnt <= w_retry_cnt_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_haddr_next     = r_haddr;
    w_htrans_next    = r_htrans;
    w_hwrite_next    = r_hwrite;
    w_hwdata_next    = r_hwdata;
    w_wdata_next     = r_wdata;
    w_dout_next      = r_dout;
    w_ack_next       = 1'b0;
    w_err_next       = 1'b0;
    w_retry_cnt_next = r_retry_cnt;

    case (r_state)
      S_IDLE: begin
        if (wb_cyc && wb_stb) begin
          w_haddr_next  = wb_addr;
          w_hwrite_next = wb_we;
          w_wdata_next  = wb_data_in;
          w_htrans_next = HTRANS_NONSEQ;
          w_state_next  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (hready) begin
          w_htrans_next = HTRANS_IDLE;
          if (r_hwrite) w_hwdata_next = r_wdata;
          w_state_next  = S_DATA;
        end
      end
      S_DATA: begin
        // A dropped wb_cyc still lets the AHB beat finish, but nothing is reported back.
        if (hready) begin
          if (hresp == HRESP_OKAY) begin
            w_ack_next = wb_cyc;
            if (wb_cyc && !r_hwrite) w_dout_next = hrdata;
            w_state_next = S_DONE;
          end else if (hresp == HRESP_ERROR) begin
            w_err_next   = wb_cyc;
            w_state_next = S_DONE;
          end else if (r_retry_cnt < MAX_CNT) begin
            w_retry_cnt_next = r_retry_cnt + CNT_W'(1);
            w_htrans_next    = HTRANS_NONSEQ;
            w_state_next     = S_ADDR;
          end else begin
            w_err_next   = wb_cyc;
            w_state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_retry_cnt_next = '0;
        w_state_next     = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign hclk        = wb_clk;
  assign hresetn     = ~wb_rst;
  assign hsize       = HSIZE_VAL;
  assign hburst      = 3'b000;
  assign haddr       = r_haddr;
  assign htrans      = r_htrans;
  assign hwrite      = r_hwrite;
  assign hwdata      = r_hwdata;
  assign wb_data_out = r_dout;
  assign wb_ack      = r_ack;
  assign wb_err      = r_err;

endmodule

// File: tb/tb_wb2ahb.sv
// Directed bench for wb2ahb: table of WB transactions against a scripted AHB slave,
// plus hand sequences for back-to-back, abort and mid-transfer reset.
module tb_wb2ahb;

  logic       wb_clk, wb_rst, wb_cyc, wb_stb, wb_we;
  logic [1:0] wb_addr;
  logic [7:0] wb_data_in, wb_data_out;
  logic       wb_ack, wb_err, hclk, hresetn, hwrite, hready;
  logic [1:0] haddr, htrans, hresp;
  logic [2:0] hsize, hburst;
  logic [7:0] hwdata, hrdata;

  wb2ahb #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .HSIZE_VAL(3'b000), .MAX_RETRY(3)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data_in(wb_data_in), .wb_data_out(wb_data_out),
    .wb_ack(wb_ack), .wb_err(wb_err), .hclk(hclk), .hresetn(hresetn), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         n_wait;
    int         n_retry;
    logic [1:0] resp;
    logic       exp_ack;
    logic       exp_err;
    logic [7:0] exp_dout;
    int         exp_nonseq;
    int         exp_edges;
  } vec_t;

  vec_t       vecs[8];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_hwdata = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int         edges, dp, nonseq;
    bit         done;
    logic [1:0] r;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = v.we; wb_addr = v.addr; wb_data_in = v.wdata;
    hready = 1'b1; hresp = 2'b00; hrdata = v.rdata;
    step();
    // Scramble WB inputs: the bridge must use the values it latched.
    wb_addr = ~v.addr; wb_data_in = ~v.wdata; wb_we = ~v.we;
    edges = 0; dp = 0; nonseq = 0; done = 1'b0;
    while (!done && edges < 40) begin
      chk($sformatf("txn%0d_nonseq_htrans", idx), htrans, 2'b10);
      chk($sformatf("txn%0d_nonseq_haddr", idx), haddr, v.addr);
      chk($sformatf("txn%0d_nonseq_hwrite", idx), hwrite, v.we);
      nonseq++;
      hready = 1'b1; hresp = 2'b00;
      step(); edges++;
      if (v.we) exp_hwdata = v.wdata;
      chk($sformatf("txn%0d_data_htrans", idx), htrans, 2'b00);
      chk($sformatf("txn%0d_hwdata", idx), hwdata, exp_hwdata);
      for (int w = 0; w < v.n_wait; w++) begin
        hready = 1'b0;
        hresp = (v.resp == 2'b01 && w == v.n_wait - 1) ? 2'b01 : 2'b00;
        step(); edges++;
        chk($sformatf("txn%0d_wait_ackerr", idx), {wb_ack, wb_err}, 2'b00);
      end
      r = (dp < v.n_retry) ? ((dp % 2 == 1) ? 2'b11 : 2'b10) : v.resp;
      hready = 1'b1; hresp = r;
      step(); edges++; dp++;
      if (htrans != 2'b10) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL txn%0d_timeout: got %0d edges required completion", idx, edges);
    end
    chk($sformatf("txn%0d_ack", idx), wb_ack, v.exp_ack);
    chk($sformatf("txn%0d_err", idx), wb_err, v.exp_err);
    chk($sformatf("txn%0d_dout", idx), wb_data_out, v.exp_dout);
    chk($sformatf("txn%0d_nonseq_count", idx), nonseq, v.exp_nonseq);
    chk($sformatf("txn%0d_latency", idx), edges, v.exp_edges);
    $display("txn %0d: we=%0b addr=%0h ack=%0b err=%0b dout=%02h nonseq=%0d edges=%0d",
             idx, v.we, v.addr, wb_ack, wb_err, wb_data_out, nonseq, edges);
    wb_cyc = 1'b0; wb_stb = 1'b0; hready = 1'b1; hresp = 2'b00;
    step();
    chk($sformatf("txn%0d_done_pulse", idx), {wb_ack, wb_err, htrans}, 4'b0000);
  endtask

  initial begin
    //          we   addr  wdata  rdata  wait retry resp   ack   err   dout  nseq edges
    vecs[0] = '{1'b1, 2'h1, 8'hA5, 8'h00, 0, 0, 2'b00, 1'b1, 1'b0, 8'h00, 1, 2};
    vecs[1] = '{1'b0, 2'h2, 8'h00, 8'h3C, 2, 0, 2'b00, 1'b1, 1'b0, 8'h3C, 1, 4};
    vecs[2] = '{1'b0, 2'h3, 8'h00, 8'h77, 1, 0, 2'b01, 1'b0, 1'b1, 8'h3C, 1, 3};
    vecs[3] = '{1'b1, 2'h0, 8'h5A, 8'h11, 0, 2, 2'b00, 1'b1, 1'b0, 8'h3C, 3, 6};
    vecs[4] = '{1'b0, 2'h1, 8'h00, 8'h99, 0, 4, 2'b00, 1'b0, 1'b1, 8'h3C, 4, 8};
    vecs[5] = '{1'b0, 2'h0, 8'h00, 8'hC3, 0, 1, 2'b00, 1'b1, 1'b0, 8'hC3, 2, 4};
    vecs[6] = '{1'b1, 2'h2, 8'h0F, 8'h00, 3, 0, 2'b00, 1'b1, 1'b0, 8'hC3, 1, 5};
    vecs[7] = '{1'b0, 2'h3, 8'h00, 8'hE1, 0, 0, 2'b01, 1'b0, 1'b1, 8'hC3, 1, 2};

    wb_rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_addr = 2'h0;
    wb_data_in = 8'h00; hrdata = 8'h00; hready = 1'b1; hresp = 2'b00;
    step(); step();
    chk("reset_outputs", {htrans, haddr, hwrite, hwdata, wb_data_out, wb_ack, wb_err}, 24'h0);
    chk("reset_hresetn", hresetn, 1'b0);
    chk("const_hsize_hburst", {hsize, hburst}, 6'b000000);
    wb_rst = 1'b0;
    step();
    chk("hresetn_released", hresetn, 1'b1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Back-to-back: stb held across ack, next NONSEQ at k+4.
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = 2'h1; wb_data_in = 8'h11;
    hready = 1'b1; hresp = 2'b00; hrdata = 8'h22;
    step();
    chk("b2b_first_nonseq", {htrans, haddr}, 4'b1001);
    step();
    chk("b2b_hwdata", hwdata, 8'h11);
    step();
    chk("b2b_first_ack", {wb_ack, wb_err}, 2'b10);
    wb_we = 1'b0; wb_addr = 2'h3;
    step();
    chk("b2b_done_turnaround", {wb_ack, htrans}, 3'b000);
    step();
    chk("b2b_second_nonseq", {htrans, haddr, hwrite}, 5'b10110);
    step(); step();
    chk("b2b_second_ack", {wb_ack, wb_err, wb_data_out}, 10'h222);
    $display("txn b2b: ack=%0b dout=%02h", wb_ack, wb_data_out);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    step();

    // Abort: cyc dropped during data phase; AHB completes, no ack, data unchanged.
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 2'h0; hrdata = 8'hAA;
    step(); step();
    wb_cyc = 1'b0; wb_stb = 1'b0; hready = 1'b0;
    step();
    chk("abort_wait_ackerr", {wb_ack, wb_err}, 2'b00);
    hready = 1'b1;
    step();
    chk("abort_no_ack", {wb_ack, wb_err, htrans}, 4'b0000);
    chk("abort_dout_kept", wb_data_out, 8'h22);
    step();
    chk("abort_done_quiet", {wb_ack, wb_err, htrans}, 4'b0000);
    $display("txn abort: ack=%0b err=%0b dout=%02h", wb_ack, wb_err, wb_data_out);

    // Reset during ADDR acts immediately, then a fresh read must work.
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = 2'h2; wb_data_in = 8'h44;
    step();
    chk("rst_pre_nonseq", htrans, 2'b10);
    #3 wb_rst = 1'b1;
    #1;
    chk("rst_async_htrans", htrans, 2'b00);
    chk("rst_async_outputs", {haddr, hwrite, hwdata, wb_data_out, wb_ack, wb_err, hresetn}, 22'h0);
    $display("txn reset: htrans=%0b dout=%02h", htrans, wb_data_out);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    step();
    wb_rst = 1'b0;
    exp_hwdata = 8'h00;
    step();
    run_vec('{1'b0, 2'h2, 8'h00, 8'h5E, 0, 0, 2'b00, 1'b1, 1'b0, 8'h5E, 1, 2}, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
